// File: rtl/fsm_oe8s_pkg.sv
// Shared types for the 8-state FSM monitor: state encoding, event header, defaults
// and the one-hot sample encoder.
package fsm_oe8s_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_e;

  // Dwell width is a module parameter, so it travels beside this header in the FIFO word.
  typedef struct packed {
    state_e src;
    state_e dst;
  } evt_hdr_t;

  // Returns {valid, index}; valid only when exactly one flag is set.
  function automatic logic [3:0] onehot_enc(input logic [7:0] v);
    logic [3:0] r;
    int n;
    r = '0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        n++;
        r[2:0] = 3'(i);
      end
    end
    r[3] = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/fsm_oe8s_evt_fifo.sv
// Synchronous FIFO for transition events; write visible at head one cycle after push.
// Push while full is ignored unless a pop happens in the same cycle; head reads 0 when empty.
module fsm_oe8s_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra MSB on each pointer separates full from empty; low bits wrap modulo DEPTH.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/fsm_oe8s_monitor.sv
// Watches one-hot state flags, tracks dwell per state, queues transition events, strobes on timeout.
// State/dwell/flags update one cycle after sampling; events drop (ovf) only when the queue is full and not popping.
module fsm_oe8s_monitor
  import fsm_oe8s_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st0,
  input  logic             st1,
  input  logic             st2,
  input  logic             st3,
  input  logic             st4,
  input  logic             st5,
  input  logic             st6,
  input  logic             st7,
  input  logic [CNT_W-1:0] timeout_lim,
  input  logic             clr,
  output logic [2:0]       cur_st,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [2:0]       ev_from,
  output logic [2:0]       ev_to,
  output logic [CNT_W-1:0] ev_dwell,
  output logic             to_pulse,
  output logic             err_onehot,
  output logic             ovf
);

  localparam int EW = $bits(evt_hdr_t) + CNT_W;
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  state_e           cur_q;
  state_e           samp_st;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] dwell_nxt;
  logic [3:0]       enc;
  logic             samp_ok;
  logic             st_change;
  logic             hit;
  logic             fire;
  logic             fired_q;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  evt_hdr_t         push_hdr;
  evt_hdr_t         head_hdr;
  logic [EW-1:0]    head_dat;

  always_comb begin
    enc       = onehot_enc({st7, st6, st5, st4, st3, st2, st1, st0});
    samp_ok   = enc[3];
    samp_st   = state_e'(enc[2:0]);
    st_change = samp_ok && (samp_st != cur_q);

    dwell_nxt = dwell_q;
    if (st_change) begin
      dwell_nxt = CNT_W'(1);
    end else if (samp_ok && (dwell_q != DWELL_MAX)) begin
      dwell_nxt = dwell_q + CNT_W'(1);
    end

    // fired_q blocks re-firing while dwell sits at the limit (saturation or frozen samples).
    hit  = (timeout_lim != '0) && (dwell_nxt == timeout_lim);
    fire = hit && (st_change || !fired_q);

    push_hdr.src = cur_q;
    push_hdr.dst = samp_st;
    pop          = !empty && ev_ready;
    drop         = st_change && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q      <= S0;
      dwell_q    <= '0;
      fired_q    <= 1'b0;
      to_pulse   <= 1'b0;
      err_onehot <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (samp_ok) cur_q <= samp_st;
      dwell_q    <= dwell_nxt;
      fired_q    <= st_change ? fire : (fired_q | fire);
      to_pulse   <= fire;
      err_onehot <= !samp_ok || (err_onehot && !clr);
      ovf        <= drop || (ovf && !clr);
    end
  end

  fsm_oe8s_evt_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (st_change),
    .wr_dat ({push_hdr, dwell_q}),
    .pop    (pop),
    .rd_dat (head_dat),
    .full   (full),
    .empty  (empty)
  );

  assign {head_hdr, ev_dwell} = head_dat;
  assign ev_from   = head_hdr.src;
  assign ev_to     = head_hdr.dst;
  assign ev_valid  = !empty;
  assign cur_st    = cur_q;
  assign dwell_cnt = dwell_q;

endmodule

// File: tb/tb_fsm_oe8s_monitor.sv
// Directed bench for fsm_oe8s_monitor: inputs change and outputs are read 1ns after each rising edge.
module tb_fsm_oe8s_monitor;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       st_v;
  logic [CNT_W-1:0] lim;
  logic             clr;
  logic             ev_ready;
  logic [2:0]       cur_st;
  logic [CNT_W-1:0] dwell_cnt;
  logic             ev_valid;
  logic [2:0]       ev_from;
  logic [2:0]       ev_to;
  logic [CNT_W-1:0] ev_dwell;
  logic             to_pulse;
  logic             err_onehot;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_oe8s_monitor #(.CNT_W(CNT_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st0(st_v[0]), .st1(st_v[1]), .st2(st_v[2]), .st3(st_v[3]),
    .st4(st_v[4]), .st5(st_v[5]), .st6(st_v[6]), .st7(st_v[7]),
    .timeout_lim(lim), .clr(clr),
    .cur_st(cur_st), .dwell_cnt(dwell_cnt),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_from(ev_from), .ev_to(ev_to), .ev_dwell(ev_dwell),
    .to_pulse(to_pulse), .err_onehot(err_onehot), .ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int s);
    st_v = '0;
    st_v[s] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; ev_ready = 1'b0; lim = '0; go(0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b1; ev_ready = 1'b1; lim = 16'd1; st_v = 8'h24;
    tick(); tick();
    n_checks++; if (cur_st !== 3'd0) begin n_fail++; $display("FAIL reset_cur_st: got %0d expected 0", cur_st); end
    n_checks++; if (dwell_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_dwell: got %0d expected 0", dwell_cnt); end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %0b expected 0", ev_valid); end
    n_checks++; if ({ev_from, ev_to, ev_dwell} !== 22'd0) begin n_fail++; $display("FAIL reset_ev_head: got %0d/%0d/%0d expected 0/0/0", ev_from, ev_to, ev_dwell); end
    n_checks++; if ({to_pulse, err_onehot, ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {to_pulse, err_onehot, ovf}); end
    rst = 1'b0; clr = 1'b0; ev_ready = 1'b0; lim = '0;
  endtask

  task automatic test_basic();
    do_reset();
    repeat (5) tick();
    n_checks++; if (dwell_cnt !== 16'd5) begin n_fail++; $display("FAIL basic_dwell5: got %0d expected 5", dwell_cnt); end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_event: got %0b expected 0", ev_valid); end
    go(3);
    tick();
    n_checks++; if ({ev_valid, ev_from, ev_to, ev_dwell} !== {1'b1, 3'd0, 3'd3, 16'd5}) begin n_fail++; $display("FAIL basic_event: got v=%0b %0d->%0d dw=%0d expected v=1 0->3 dw=5", ev_valid, ev_from, ev_to, ev_dwell); end
    n_checks++; if ({cur_st, dwell_cnt} !== {3'd3, 16'd1}) begin n_fail++; $display("FAIL basic_cur_after: got st=%0d dw=%0d expected st=3 dw=1", cur_st, dwell_cnt); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    n_checks++; if ({ev_valid, dwell_cnt} !== {1'b0, 16'd2}) begin n_fail++; $display("FAIL basic_pop: got v=%0b dw=%0d expected v=0 dw=2", ev_valid, dwell_cnt); end
  endtask

  task automatic test_overflow();
    int seq[6]   = '{1, 4, 6, 2, 7, 0};
    int e_src[4] = '{0, 1, 4, 6};
    int e_dst[4] = '{1, 4, 6, 2};
    int e_dw[4]  = '{1, 2, 2, 2};
    do_reset();
    tick();
    for (int i = 0; i < 6; i++) begin
      go(seq[i]);
      tick(); tick();
    end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b expected 1", ovf); end
    n_checks++; if ({ev_valid, ev_from, ev_to, ev_dwell} !== {1'b1, 3'd0, 3'd1, 16'd1}) begin n_fail++; $display("FAIL ovf_head_stable: got v=%0b %0d->%0d dw=%0d expected v=1 0->1 dw=1", ev_valid, ev_from, ev_to, ev_dwell); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if ({ovf, ev_valid, ev_to} !== {1'b0, 1'b1, 3'd1}) begin n_fail++; $display("FAIL ovf_clr_keeps_fifo: got ovf=%0b v=%0b to=%0d expected ovf=0 v=1 to=1", ovf, ev_valid, ev_to); end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ev_valid, ev_from, ev_to, ev_dwell} !== {1'b1, 3'(e_src[i]), 3'(e_dst[i]), 16'(e_dw[i])}) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d: got v=%0b %0d->%0d dw=%0d expected v=1 %0d->%0d dw=%0d", i, ev_valid, ev_from, ev_to, ev_dwell, e_src[i], e_dst[i], e_dw[i]);
      end
      tick();
    end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %0b expected 0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  task automatic test_onehot_err();
    do_reset();
    repeat (3) tick();
    st_v = 8'b0010_0100;
    tick();
    n_checks++; if ({err_onehot, cur_st, dwell_cnt, ev_valid} !== {1'b1, 3'd0, 16'd3, 1'b0}) begin n_fail++; $display("FAIL err_multi: got err=%0b st=%0d dw=%0d v=%0b expected err=1 st=0 dw=3 v=0", err_onehot, cur_st, dwell_cnt, ev_valid); end
    st_v = 8'h00;
    tick();
    n_checks++; if ({err_onehot, dwell_cnt} !== {1'b1, 16'd3}) begin n_fail++; $display("FAIL err_zero: got err=%0b dw=%0d expected err=1 dw=3", err_onehot, dwell_cnt); end
    go(0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if ({err_onehot, dwell_cnt} !== {1'b0, 16'd5}) begin n_fail++; $display("FAIL err_clr: got err=%0b dw=%0d expected err=0 dw=5", err_onehot, dwell_cnt); end
    clr = 1'b1; st_v = 8'hFF;
    tick();
    clr = 1'b0;
    n_checks++; if ({err_onehot, dwell_cnt} !== {1'b1, 16'd5}) begin n_fail++; $display("FAIL err_set_wins: got err=%0b dw=%0d expected err=1 dw=5", err_onehot, dwell_cnt); end
    go(0);
  endtask

  task automatic test_timeout();
    int pulses;
    int exp_dw;
    do_reset();
    lim = 16'd10; ev_ready = 1'b1;
    go(1);
    tick();
    exp_dw = 1; pulses = 0;
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if ({to_pulse, dwell_cnt} !== {exp_dw == 10, 16'(exp_dw)}) begin
        n_fail++;
        $display("FAIL to_cycle_%0d: got pulse=%0b dw=%0d expected pulse=%0b dw=%0d", i, to_pulse, dwell_cnt, exp_dw == 10, exp_dw);
      end
      pulses += int'(to_pulse);
      tick();
      exp_dw++;
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL to_once: got %0d pulses expected 1", pulses); end
    go(2);
    tick();
    repeat (9) tick();
    n_checks++; if ({to_pulse, dwell_cnt} !== {1'b1, 16'd10}) begin n_fail++; $display("FAIL to_rearm: got pulse=%0b dw=%0d expected pulse=1 dw=10", to_pulse, dwell_cnt); end
    st_v = 8'h00;
    tick();
    n_checks++; if ({to_pulse, dwell_cnt} !== {1'b0, 16'd10}) begin n_fail++; $display("FAIL to_frozen_no_retrigger: got pulse=%0b dw=%0d expected pulse=0 dw=10", to_pulse, dwell_cnt); end
    go(2);
    tick();
    n_checks++; if ({to_pulse, dwell_cnt} !== {1'b0, 16'd11}) begin n_fail++; $display("FAIL to_after_freeze: got pulse=%0b dw=%0d expected pulse=0 dw=11", to_pulse, dwell_cnt); end
    lim = '0;
    go(3);
    pulses = 0;
    repeat (14) begin
      tick();
      pulses += int'(to_pulse);
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL to_disabled: got %0d pulses expected 0", pulses); end
    ev_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    tick();
    for (int s = 1; s <= 4; s++) begin
      go(s);
      tick();
    end
    ev_ready = 1'b1;
    go(5);
    tick();
    ev_ready = 1'b0;
    n_checks++; if ({ovf, ev_valid, ev_from, ev_to} !== {1'b0, 1'b1, 3'd1, 3'd2}) begin n_fail++; $display("FAIL full_pop_push: got ovf=%0b v=%0b %0d->%0d expected ovf=0 v=1 1->2", ovf, ev_valid, ev_from, ev_to); end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ev_valid, ev_from, ev_to, ev_dwell} !== {1'b1, 3'(i + 1), 3'(i + 2), 16'd1}) begin
        n_fail++;
        $display("FAIL full_drain_%0d: got v=%0b %0d->%0d dw=%0d expected v=1 %0d->%0d dw=1", i, ev_valid, ev_from, ev_to, ev_dwell, i + 1, i + 2);
      end
      tick();
    end
    n_checks++; if ({ev_valid, ovf} !== 2'b00) begin n_fail++; $display("FAIL full_drained: got v=%0b ovf=%0b expected v=0 ovf=0", ev_valid, ovf); end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    lim = 16'd2;
    go(1); tick();
    go(2); tick();
    st_v = 8'h00; tick();
    go(3); tick();
    n_checks++; if ({ev_valid, err_onehot, cur_st, dwell_cnt} !== {1'b1, 1'b1, 3'd3, 16'd1}) begin n_fail++; $display("FAIL mid_precond: got v=%0b err=%0b st=%0d dw=%0d expected v=1 err=1 st=3 dw=1", ev_valid, err_onehot, cur_st, dwell_cnt); end
    rst = 1'b1; clr = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0;
    n_checks++; if ({ev_valid, cur_st, dwell_cnt} !== {1'b0, 3'd0, 16'd0}) begin n_fail++; $display("FAIL mid_reset_state: got v=%0b st=%0d dw=%0d expected v=0 st=0 dw=0", ev_valid, cur_st, dwell_cnt); end
    n_checks++; if ({to_pulse, err_onehot, ovf} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 000", {to_pulse, err_onehot, ovf}); end
    n_checks++; if ({ev_from, ev_to, ev_dwell} !== 22'd0) begin n_fail++; $display("FAIL mid_reset_head: got %0d/%0d/%0d expected 0/0/0", ev_from, ev_to, ev_dwell); end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ev_ready = 1'b0; lim = '0; st_v = 8'h01;
    test_reset();
    test_basic();
    test_overflow();
    test_onehot_err();
    test_timeout();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_oe8s_monitor.md
FSM_OE8S_MONITOR -- requirements
Module: fsm_oe8s_monitor

Interface
REQ-001 Parameter CNT_W, default 16: dwell counter and timeout width.
REQ-002 Parameter FIFO_DEPTH, default 4: transition-event FIFO depth, power of two, at least 2.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 st0..st7  input  1 each  one-hot state flags from the upstream 8-state FSM.
REQ-006 timeout_lim  input  CNT_W  dwell timeout threshold; 0 disables timeout.
REQ-007 clr  input  1  synchronous clear of sticky flags.
REQ-008 cur_st  output  3  encoded last valid observed state.
REQ-009 dwell_cnt  output  CNT_W  consecutive cycles in cur_st.
REQ-010 ev_valid  output  1  event FIFO non-empty.
REQ-011 ev_ready  input  1  consumer accepts the head event.
REQ-012 ev_from, ev_to  output  3 each  head event source state and destination state.
REQ-013 ev_dwell  output  CNT_W  head event dwell in ev_from.
REQ-014 to_pulse  output  1  one-cycle timeout strobe.
REQ-015 err_onehot  output  1  sticky: invalid one-hot sample seen.
REQ-016 ovf  output  1  sticky: event dropped because FIFO full.

Function
REQ-017 Each cycle the monitor SHALL sample st0..st7; a sample is valid iff exactly one bit is set, encoded as index 0..7.
REQ-018 Invalid sample (zero or more than one bit set): the monitor SHALL set err_onehot and leave cur_st and dwell_cnt unchanged, with no event.
REQ-019 Valid sample equal to cur_st: dwell_cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-020 Valid sample s not equal to cur_st: the monitor SHALL push event {from=cur_st, to=s, dwell=dwell_cnt}, set cur_st to s and dwell_cnt to 1.
REQ-021 Latency: an event SHALL be visible at the FIFO head no earlier than 1 cycle after its sample edge.
REQ-022 A pushed event SHALL appear at ev_valid exactly 1 cycle after its sample edge when the FIFO was empty.
REQ-023 Pop SHALL occur iff ev_valid and ev_ready; ev_from, ev_to and ev_dwell SHALL be stable while ev_valid is high and ev_ready is low.
REQ-024 FIFO full with a push and no pop: the new event SHALL be dropped and ovf set; stored events are unaffected.
REQ-025 FIFO full with push and pop in the same cycle: both SHALL complete and the count stays at FIFO_DEPTH.
REQ-026 Pop on empty SHALL be impossible, since ev_valid is 0.
REQ-027 to_pulse SHALL be high for exactly the one cycle in which the registered dwell_cnt first equals a nonzero timeout_lim.
REQ-028 Saturation SHALL not retrigger to_pulse.
REQ-029 to_pulse SHALL rearm on a state change.
REQ-030 clr SHALL clear err_onehot and ovf next cycle and SHALL NOT flush the FIFO or touch the counters.
REQ-031 clr coinciding with a new error SHALL leave the flag set; set wins.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 On rst: cur_st=0, dwell_cnt=0, FIFO empty (ev_valid=0), ev_from/ev_to/ev_dwell=0, to_pulse=0, err_onehot=0, ovf=0.
REQ-034 rst mid-operation SHALL discard all queued events and abort any pending to_pulse.
REQ-035 rst SHALL take priority over clr and over all sampling.

Structure
REQ-036 Package fsm_oe8s_pkg SHALL hold the 3-bit state enum (S0..S7), the event struct typedef, and the CNT_W and FIFO_DEPTH defaults.
REQ-037 The FIFO SHALL be a sub-module fsm_oe8s_evt_fifo: synchronous, parameterised depth, push/pop/full/empty.
REQ-038 The one-hot checker, encoder, dwell counter and timeout logic SHALL reside in the top module.

Verification
REQ-039 After reset, hold st0 for 5 cycles, then st3 -> one event {0,3,5}, ev_valid 1 cycle after the switch, then dwell_cnt=1 with cur_st=3.
REQ-040 With ev_ready=0, make 6 transitions -> 4 events kept in order, ovf=1; then drain with ev_ready=1 -> 4 pops, then ev_valid=0.
REQ-041 Drive st2 and st5 together for 1 cycle -> err_onehot=1, cur_st and dwell_cnt frozen; then pulse clr -> err_onehot=0 next cycle.
REQ-042 timeout_lim=10, hold state -> to_pulse high exactly once, in the cycle dwell_cnt=10; set timeout_lim=0 -> no pulse.
REQ-043 FIFO full and ev_ready=1 while a transition arrives -> no drop, ovf stays 0, count stays 4.
REQ-044 Assert rst with 3 queued events -> next cycle ev_valid=0, cur_st=0, dwell_cnt=0, all flags 0.
